// File: rtl/pmp_pkg.sv
// Shared encodings for the PMP checker: cfg byte layout, A-field modes,
// access type / privilege codes and the checker FSM states.
package pmp_pkg;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam int CFG_R     = 0;
  localparam int CFG_W     = 1;
  localparam int CFG_X     = 2;
  localparam int CFG_A_LSB = 3;
  localparam int CFG_L     = 7;

  localparam logic [1:0] TYPE_R    = 2'd0;
  localparam logic [1:0] TYPE_W    = 2'd1;
  localparam logic [1:0] TYPE_X    = 2'd2;
  localparam logic [1:0] TYPE_RSVD = 2'd3;

  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match for a single PMP entry (OFF/TOR/NA4/NAPOT),
// all comparisons on word addresses.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EW   = 32
) (
  input  logic [1:0]      i_mode,
  input  logic [XLEN-1:0] i_addr,
  input  logic [EW-1:0]   i_prev_ea,
  input  logic [EW-1:0]   i_wa,
  output logic            o_match
);

  logic [EW-1:0]   w_ea;
  logic [XLEN-1:0] w_low;

  assign w_ea = i_addr[EW-1:0];
  // addr ^ (addr+1) sets bit t and every trailing one below it; an all-ones
  // pmpaddr wraps to zero and so masks every bit, matching everything.
  assign w_low = i_addr ^ (i_addr + XLEN'(1));

  always_comb begin
    o_match = 1'b0;
    case (i_mode)
      A_TOR:   o_match = (i_wa >= i_prev_ea) && (i_wa < w_ea);
      A_NA4:   o_match = (i_wa == w_ea);
      A_NAPOT: o_match = (((i_wa ^ w_ea) & ~w_low[EW-1:0]) == '0);
      default: o_match = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_checker.sv
// Sequential PMP checker: scans ENTRIES entries LANES at a time, lowest index wins.
// Optional one-entry last-result cache enabled by defining PMP_LAST_HIT_EN.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int LANES     = 4,
  parameter int XLEN      = 32,
  parameter int PADDR_LEN = 34
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ENTRIES*8-1:0]        pmpcfg,
  input  logic [ENTRIES*XLEN-1:0]     pmpaddr,
  input  logic                        cfg_wr,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [PADDR_LEN-1:0]        req_addr,
  input  logic [1:0]                  req_type,
  input  logic [1:0]                  req_priv,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_fault,
  output logic                        resp_hit,
  output logic [$clog2(ENTRIES)-1:0]  resp_idx
);

  localparam int EW  = PADDR_LEN - 2;
  localparam int NCH = ENTRIES / LANES;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW  = $clog2(ENTRIES);
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

  state_e           r_state, w_next;
  logic [CW-1:0]    r_chunk;
  logic [EW-1:0]    r_wa;
  logic [1:0]       r_type, r_priv;
  logic             r_fault, r_hit;
  logic [IW-1:0]    r_idx;

  logic [7:0]       w_cfg_all  [ENTRIES];
  logic [XLEN-1:0]  w_addr_all [ENTRIES];
  logic [EW-1:0]    w_ea_all   [ENTRIES];
  logic [IW-1:0]    w_eidx     [LANES];
  logic [7:0]       w_cfg      [LANES];
  logic [XLEN-1:0]  w_addr     [LANES];
  logic [EW-1:0]    w_prev     [LANES];
  logic [LANES-1:0] w_match;
  logic             w_any, w_last;
  logic [LW-1:0]    w_lane;
  logic             w_cache_hit, w_c_fault, w_c_hit;
  logic [IW-1:0]    w_c_idx;
  logic             w_unused;

  assign w_unused = ^{req_addr[1:0], w_cfg[0][6:5]};

  function automatic logic f_fault(input logic hit, input logic [7:0] cfg,
                                   input logic [1:0] rtype, input logic [1:0] priv);
    logic perm;
    case (rtype)
      TYPE_R:  perm = cfg[CFG_R];
      TYPE_W:  perm = cfg[CFG_W];
      TYPE_X:  perm = cfg[CFG_X];
      default: perm = 1'b0;
    endcase
    if (rtype == TYPE_RSVD)                    f_fault = 1'b1;
    else if (!hit)                             f_fault = (priv != PRIV_M);
    else if ((priv == PRIV_M) && !cfg[CFG_L])  f_fault = 1'b0;
    else                                       f_fault = !perm;
  endfunction

  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    assign w_cfg_all[e]  = pmpcfg[8*e +: 8];
    assign w_addr_all[e] = pmpaddr[XLEN*e +: XLEN];
    assign w_ea_all[e]   = pmpaddr[XLEN*e +: EW];
  end

  // Lane g of the current chunk looks at entry chunk*LANES+g; TOR needs its predecessor.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_eidx[g] = IW'(32'(r_chunk) * 32'(LANES) + 32'(g));
    assign w_cfg[g]  = w_cfg_all[w_eidx[g]];
    assign w_addr[g] = w_addr_all[w_eidx[g]];
    assign w_prev[g] = (w_eidx[g] == '0) ? '0 : w_ea_all[w_eidx[g] - IW'(1)];

    pmp_entry_match #(.XLEN(XLEN), .EW(EW)) u_match (
      .i_mode    (w_cfg[g][CFG_A_LSB +: 2]),
      .i_addr    (w_addr[g]),
      .i_prev_ea (w_prev[g]),
      .i_wa      (r_wa),
      .o_match   (w_match[g])
    );
  end

  always_comb begin
    w_any  = 1'b0;
    w_lane = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_match[l]) begin
        w_any  = 1'b1;
        w_lane = LW'(l);
      end
    end
  end

  assign w_last = (r_chunk == CW'(NCH - 1));

`ifdef PMP_LAST_HIT_EN
  logic          r_c_vld;
  logic [EW-1:0] r_c_wa;
  logic [1:0]    r_c_type, r_c_priv;
  logic          r_c_fault, r_c_hit;
  logic [IW-1:0] r_c_idx;

  assign w_cache_hit = r_c_vld && !cfg_wr && (r_c_wa == req_addr[PADDR_LEN-1:2]) &&
                       (r_c_type == req_type) && (r_c_priv == req_priv);
  assign w_c_fault = r_c_fault;
  assign w_c_hit   = r_c_hit;
  assign w_c_idx   = r_c_idx;

  always_ff @(posedge clk) begin
    if (rst || cfg_wr)                          r_c_vld <= 1'b0;
    else if ((r_state == ST_RESP) && resp_ready) r_c_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if ((r_state == ST_RESP) && resp_ready) begin
      r_c_wa    <= r_wa;
      r_c_type  <= r_type;
      r_c_priv  <= r_priv;
      r_c_fault <= r_fault;
      r_c_hit   <= r_hit;
      r_c_idx   <= r_idx;
    end
  end
`else
  assign w_cache_hit = 1'b0;
  assign w_c_fault   = 1'b0;
  assign w_c_hit     = 1'b0;
  assign w_c_idx     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = w_cache_hit ? ST_RESP : ST_SCAN;
      ST_SCAN: if (!cfg_wr && (w_any || w_last)) w_next = ST_RESP;
      ST_RESP: if (resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
    resp_fault = r_fault;
    resp_hit   = r_hit;
    resp_idx   = r_idx;
  end

  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && req_valid) begin
      r_wa   <= req_addr[PADDR_LEN-1:2];
      r_type <= req_type;
      r_priv <= req_priv;
    end
  end

  // A CSR write mid-scan discards this chunk's verdict and rescans with the new config.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chunk <= '0;
      r_fault <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_chunk <= '0;
          if (w_cache_hit) begin
            r_fault <= w_c_fault;
            r_hit   <= w_c_hit;
            r_idx   <= w_c_idx;
          end
        end
        ST_SCAN: begin
          if (cfg_wr) begin
            r_chunk <= '0;
          end else if (w_any) begin
            r_hit   <= 1'b1;
            r_idx   <= w_eidx[w_lane];
            r_fault <= f_fault(1'b1, w_cfg[w_lane], r_type, r_priv);
          end else if (w_last) begin
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_fault <= f_fault(1'b0, 8'h00, r_type, r_priv);
          end else begin
            r_chunk <= r_chunk + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_checker.sv
// Directed bench for pmp_checker with an address-range reference model and
// an optional last-result cache model (tracks PMP_LAST_HIT_EN).
module tb_pmp_checker;

  localparam int ENTRIES = 16;
  localparam int LANES   = 4;
`ifdef PMP_LAST_HIT_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, cfg_wr, req_valid, resp_ready;
  logic [127:0] pmpcfg;
  logic [511:0] pmpaddr;
  logic [33:0]  req_addr;
  logic [1:0]   req_type, req_priv;
  logic         req_ready, resp_valid, resp_fault, resp_hit;
  logic [3:0]   resp_idx;

  logic [7:0]   cfg_m  [ENTRIES];
  logic [31:0]  addr_m [ENTRIES];

  int n_checks = 0;
  int n_err    = 0;

  bit exp_fault, exp_hit, exp_active;
  int exp_idx, exp_lat;
  bit          mc_v;
  logic [31:0] mc_wa;
  logic [1:0]  mc_t, mc_p;
  bit          mc_f, mc_h;
  int          mc_i;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_pack
    assign pmpcfg[8*i +: 8]    = cfg_m[i];
    assign pmpaddr[32*i +: 32] = addr_m[i];
  end

  pmp_checker #(.ENTRIES(16), .LANES(4), .XLEN(32), .PADDR_LEN(34)) dut (
    .clk(clk), .rst(rst), .pmpcfg(pmpcfg), .pmpaddr(pmpaddr), .cfg_wr(cfg_wr),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_type(req_type), .req_priv(req_priv), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_fault(resp_fault), .resp_hit(resp_hit),
    .resp_idx(resp_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the entries as address ranges, first match decides.
  function automatic void model(input logic [33:0] a, input logic [1:0] t,
                                input logic [1:0] p, input int wr_cyc);
    longint wa, ea, lo, base, size;
    int tz;
    bit m, pm, perm;
    wa = longint'({32'b0, a[33:2]});
    exp_hit = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      ea = longint'({32'b0, addr_m[i]});
      lo = 0;
      if (i > 0) lo = longint'({32'b0, addr_m[i-1]});
      m = 1'b0;
      case (cfg_m[i][4:3])
        2'd1: m = (wa >= lo) && (wa < ea);
        2'd2: m = (wa == ea);
        2'd3: begin
          tz = 0;
          while (tz < 32 && addr_m[i][tz] == 1'b1) tz++;
          if (tz == 32) m = 1'b1;
          else begin
            size = longint'(1) << (tz + 1);
            base = ea & ~(size - 1);
            m = (wa >= base) && (wa < base + size);
          end
        end
        default: m = 1'b0;
      endcase
      if (m && !exp_hit) begin
        exp_hit = 1'b1;
        exp_idx = i;
      end
    end
    pm = (p == 2'd3);
    perm = 1'b0;
    if (exp_hit && t != 2'd3) perm = cfg_m[exp_idx][t];
    if (t == 2'd3)                            exp_fault = 1'b1;
    else if (!exp_hit)                        exp_fault = !pm;
    else if (pm && !cfg_m[exp_idx][7])        exp_fault = 1'b0;
    else                                      exp_fault = !perm;
    exp_lat = (exp_hit ? exp_idx / LANES : ENTRIES / LANES - 1) + 2 + wr_cyc;
    if (CACHE_EN && mc_v && wr_cyc == 0 && mc_wa == a[33:2] && mc_t == t && mc_p == p) begin
      exp_fault = mc_f;
      exp_hit   = mc_h;
      exp_idx   = mc_i;
      exp_lat   = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (exp_active && resp_valid) begin
      check("resp_fault", resp_fault, exp_fault);
      check("resp_hit", resp_hit, exp_hit);
      check("resp_idx", resp_idx, exp_idx);
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < ENTRIES; i++) begin
      cfg_m[i]  = 8'h00;
      addr_m[i] = 32'h0;
    end
  endtask

  task automatic pulse_wr();
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    mc_v = 1'b0;
  endtask

  task automatic do_req(input logic [33:0] a, input logic [1:0] t, input logic [1:0] p,
                        input int hold, input int wr_cyc, input int wr_e,
                        input logic [7:0] wr_c, input logic [31:0] wr_a,
                        input bit lf, input bit lh, input int li, input int ll);
    int lat;
    check("idle_ready", req_ready, 1'b1);
    model(a, t, p, 0);
    exp_active = 1'b1;
    req_addr = a; req_type = t; req_priv = p; req_valid = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        check("busy_ready", req_ready, 1'b0);
      end
      if (resp_valid) lat = c;
      else if (c == wr_cyc) begin
        cfg_m[wr_e] = wr_c;
        addr_m[wr_e] = wr_a;
        cfg_wr = 1'b1;
        model(a, t, p, wr_cyc);
        mc_v = 1'b0;
      end else cfg_wr = 1'b0;
    end
    cfg_wr = 1'b0;
    check("latency", lat, exp_lat);
    repeat (hold) begin
      @(negedge clk);
      check("held_valid", resp_valid, 1'b1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_active = 1'b0;
    check("post_valid", resp_valid, 1'b0);
    check("post_ready", req_ready, 1'b1);
    if (lat > 0) begin
      mc_v = 1'b1; mc_wa = a[33:2]; mc_t = t; mc_p = p;
      mc_f = exp_fault; mc_h = exp_hit; mc_i = exp_idx;
    end
    check("pin_fault", exp_fault, lf);
    check("pin_hit", exp_hit, lh);
    check("pin_idx", exp_idx, li);
    check("pin_lat", exp_lat, ll);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_type = '0; req_priv = '0;
    exp_active = 1'b0; mc_v = 1'b0;
    clear_cfg();
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_valid", resp_valid, 1'b0);
    check("rst_fault", resp_fault, 1'b0);
    check("rst_hit", resp_hit, 1'b0);
    check("rst_idx", resp_idx, 4'd0);
    rst = 1'b0;
    @(negedge clk);

    // All entries OFF: no hit, S/U fault, M allowed, full four-chunk scan.
    do_req(34'h1000, 2'd0, 2'd0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 5);
    do_req(34'h1000, 2'd0, 2'd3, 0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 5);

    // Entry5 NAPOT base 0, read-only; response held four cycles.
    clear_cfg(); addr_m[5] = 32'h0000_03FF; cfg_m[5] = 8'h19; pulse_wr();
    do_req(34'h0800, 2'd1, 2'd0, 4, 0, 0, 8'h00, 32'h0, 1, 1, 5, 3);
    do_req(34'h0000, 2'd0, 2'd0, 0, 0, 0, 8'h00, 32'h0, 0, 1, 5, 3);
    do_req(34'h2000, 2'd0, 2'd0, 0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 5);

    // Entry1 TOR [0,0x400) X-only, entry2 NAPOT 0x800-0x9FF RW.
    clear_cfg();
    addr_m[1] = 32'h100; cfg_m[1] = 8'h0C;
    addr_m[2] = 32'h23F; cfg_m[2] = 8'h1B;
    pulse_wr();
    do_req(34'h0900, 2'd1, 2'd1, 0, 0, 0, 8'h00, 32'h0, 0, 1, 2, 2);
    do_req(34'h03FC, 2'd1, 2'd1, 0, 0, 0, 8'h00, 32'h0, 1, 1, 1, 2);
    do_req(34'h0400, 2'd1, 2'd1, 0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 5);
    do_req(34'h03FC, 2'd2, 2'd2, 0, 0, 0, 8'h00, 32'h0, 0, 1, 1, 2);

    // Entry3 NA4 at 0x2000: lock bit binds M-mode; reserved type always faults.
    clear_cfg(); addr_m[3] = 32'h800; cfg_m[3] = 8'h90; pulse_wr();
    do_req(34'h2000, 2'd0, 2'd3, 0, 0, 0, 8'h00, 32'h0, 1, 1, 3, 2);
    do_req(34'h2000, 2'd3, 2'd3, 0, 0, 0, 8'h00, 32'h0, 1, 1, 3, 2);
    cfg_m[3] = 8'h10; pulse_wr();
    do_req(34'h2000, 2'd0, 2'd3, 0, 0, 0, 8'h00, 32'h0, 0, 1, 3, 2);
    do_req(34'h2000, 2'd0, 2'd0, 0, 0, 0, 8'h00, 32'h0, 1, 1, 3, 2);

    // Reset in the middle of a scan drops the request.
    clear_cfg(); pulse_wr();
    req_addr = 34'h1000; req_type = 2'd0; req_priv = 2'd0; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; mc_v = 1'b0;
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_hit", resp_hit, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_valid", resp_valid, 1'b0);
    end

    // CSR write in cycle 2 makes entry0 match; scan restarts at chunk 0.
    do_req(34'h1000, 2'd0, 2'd0, 0, 2, 0, 8'h11, 32'h400, 0, 1, 0, 4);

    // Identical repeat (cache hit when enabled), then repeat after a CSR write.
    do_req(34'h1000, 2'd0, 2'd0, 0, 0, 0, 8'h00, 32'h0, 0, 1, 0, CACHE_EN ? 1 : 2);
    pulse_wr();
    do_req(34'h1000, 2'd0, 2'd0, 0, 0, 0, 8'h00, 32'h0, 0, 1, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
